// File: rtl/bit_serial_subtractor.sv
// bit_serial_subtractor
//   Computes a - b - bin one bit per clock, LSB first, using a single
//   full-subtractor slice and a registered borrow. The design has a
//   start/busy/done handshake. A result is produced WIDTH cycles after
//   start is accepted.
//
// Parameters
//   WIDTH   operand/result width (>= 1)
//
// Ports
//   clk     rising-edge clock
//   rst_n   asynchronous reset, active-low
//   start   request, sampled when not busy (IDLE or DONE)
//   a, b    minuend / subtrahend, captured with start
//   bin     borrow in, captured with start
//   busy    high while the operation runs (RUN state only)
//   done    one-cycle completion pulse
//   diff    result, held between completions
//   bout    borrow out, held between completions
//
// Configuration macro
//   SERIAL_SUB_SAT_EN  when defined, diff saturates to 0 on a final borrow

module bs_fsub_slice (
    input  logic x,
    input  logic y,
    input  logic br,
    output logic d,
    output logic br_nxt
);
    assign d      = x ^ y ^ br;
    assign br_nxt = (~x & y) | (~(x ^ y) & br);
endmodule

module bit_serial_subtractor #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] a_sr, b_sr, r_sr;
    logic             br;
    logic [CW-1:0]    cnt;
    logic             d, br_nxt, last;
    logic [WIDTH:0]   r_cat;
    logic [WIDTH-1:0] r_nxt;

    bs_fsub_slice u_slice (
        .x      (a_sr[0]),
        .y      (b_sr[0]),
        .br     (br),
        .d      (d),
        .br_nxt (br_nxt)
    );

    assign last  = (cnt == CW'(WIDTH - 1));
    // New bit enters at the MSB; the concat keeps WIDTH=1 free of empty slices.
    assign r_cat = {d, r_sr};
    assign r_nxt = r_cat[WIDTH:1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE, DONE: state_nxt = start ? RUN : IDLE;
            RUN:        state_nxt = last ? DONE : RUN;
            default:    state_nxt = IDLE;
        endcase
    end

    assign busy = (state == RUN);
    assign done = (state == DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sr <= '0;
            b_sr <= '0;
            r_sr <= '0;
            br   <= 1'b0;
            cnt  <= '0;
            diff <= '0;
            bout <= 1'b0;
        end else if (state == RUN) begin
            a_sr <= a_sr >> 1;
            b_sr <= b_sr >> 1;
            r_sr <= r_nxt;
            br   <= br_nxt;
            cnt  <= cnt + CW'(1);
            if (last) begin
`ifdef SERIAL_SUB_SAT_EN
                diff <= br_nxt ? '0 : r_nxt;
`else
                diff <= r_nxt;
`endif
                bout <= br_nxt;
            end
        end else if (start) begin
            // IDLE or DONE: accept a new operation.
            a_sr <= a;
            b_sr <= b;
            r_sr <= '0;
            br   <= bin;
            cnt  <= '0;
        end
    end
endmodule

// File: tb/tb_bit_serial_subtractor.sv
module tb_bit_serial_subtractor;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [3:0] a = '0, b = '0;
    logic       bin = 1'b0;
    logic       busy, done, bout;
    logic [3:0] diff;

    int n_cmp = 0;
    int n_bad = 0;

    bit_serial_subtractor #(.WIDTH(4)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .bin(bin),
        .busy(busy), .done(done), .diff(diff), .bout(bout)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

`ifdef SERIAL_SUB_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    function automatic int sat(input int wrap_d, input int bo);
        return (SAT && bo != 0) ? 0 : wrap_d;
    endfunction

    // Full operation: start at E0, check busy E0..E3, done/result at E4,
    // done falling at E5.
    task automatic run_op(input string tag, input logic [3:0] av, input logic [3:0] bv,
                          input logic bi, input int ed, input int eb);
        a = av; b = bv; bin = bi; start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk({tag, ".busy"}, 32'(busy), 1);
            chk({tag, ".done_early"}, 32'(done), 0);
            tick();
        end
        chk({tag, ".busy3"}, 32'(busy), 1);
        tick();
        chk({tag, ".done"}, 32'(done), 1);
        chk({tag, ".busy_off"}, 32'(busy), 0);
        chk({tag, ".diff"}, 32'(diff), ed);
        chk({tag, ".bout"}, 32'(bout), eb);
        tick();
        chk({tag, ".done_fall"}, 32'(done), 0);
    endtask

    initial begin
        int pulses;
        #2;
        chk("rst.busy", 32'(busy), 0);
        chk("rst.done", 32'(done), 0);
        chk("rst.diff", 32'(diff), 0);
        chk("rst.bout", 32'(bout), 0);
        #10 rst_n = 1'b1;
        tick();

        run_op("9m3",   4'd9, 4'd3, 1'b0, 6, 0);
        run_op("3m9",   4'd3, 4'd9, 1'b0, sat(10, 1), 1);
        run_op("0m0b",  4'd0, 4'd0, 1'b1, sat(15, 1), 1);
        run_op("15m0b", 4'd15, 4'd0, 1'b1, 14, 0);
        run_op("8m7b",  4'd8, 4'd7, 1'b1, 0, 0);
        run_op("5m5b",  4'd5, 4'd5, 1'b1, sat(15, 1), 1);

        // start during RUN is ignored
        a = 4'd9; b = 4'd3; bin = 1'b0; start = 1'b1;
        tick();                      // E0
        start = 1'b0;
        tick();                      // E1
        a = 4'd1; b = 4'd1; start = 1'b1;
        pulses = 0;
        tick();                      // E2 (ignored)
        start = 1'b0;
        for (int i = 0; i < 6; i++) begin
            if (done) begin
                pulses++;
                chk("ign.diff", 32'(diff), 6);
            end
            tick();
        end
        chk("ign.pulses", pulses, 1);
        chk("ign.idle", 32'(busy), 0);

        // back-to-back with start held in the DONE cycle
        a = 4'd15; b = 4'd1; bin = 1'b0; start = 1'b1;
        tick();                      // E0
        start = 1'b0;
        tick(); tick(); tick();      // E1..E3
        tick();                      // E4
        chk("b2b.done1", 32'(done), 1);
        chk("b2b.diff1", 32'(diff), 14);
        a = 4'd5; b = 4'd5; bin = 1'b0; start = 1'b1;
        tick();                      // E5 accepted
        start = 1'b0;
        chk("b2b.busy5", 32'(busy), 1);
        chk("b2b.done5", 32'(done), 0);
        chk("b2b.hold", 32'(diff), 14);
        tick(); tick(); tick();      // E6..E8
        chk("b2b.busy8", 32'(busy), 1);
        tick();                      // E9
        chk("b2b.done2", 32'(done), 1);
        chk("b2b.diff2", 32'(diff), 0);
        chk("b2b.bout2", 32'(bout), 0);
        tick();

        // asynchronous reset mid-RUN (diff currently 0, so set 14 first)
        run_op("pre", 4'd15, 4'd1, 1'b0, 14, 0);
        a = 4'd9; b = 4'd3; bin = 1'b0; start = 1'b1;
        tick();                      // E0
        start = 1'b0;
        tick(); tick();              // E1, E2
        #2 rst_n = 1'b0;
        #1;
        chk("ar.busy", 32'(busy), 0);
        chk("ar.done", 32'(done), 0);
        chk("ar.diff", 32'(diff), 0);
        chk("ar.bout", 32'(bout), 0);
        @(negedge clk);
        rst_n = 1'b1;
        pulses = 0;
        for (int i = 0; i < 7; i++) begin
            tick();
            if (done || busy) pulses++;
        end
        chk("ar.no_done", pulses, 0);
        chk("ar.diff_after", 32'(diff), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
